// File: rtl/game_state_ctrl.sv
// game_state_ctrl: multi-level game-flow FSM with lives, timed DYING/CLEAR intervals, win detection and optional pause.
// Ports: clk, rst_n (async active-low); start/pause (rising-edge detected), restart (sync abort to IDLE),
// over/success (level, sampled in PLAY); state (IDLE=0 PLAY=1 PAUSE=2 DYING=3 CLEAR=4 OVER=5 WIN=6),
// level (0-based), lives, life_lost and level_up (one-cycle pulses). All outputs registered.
// Optional feature: define GAME_PAUSE_EN to enable the PAUSE state; otherwise pause is unused and code 2 recovers to IDLE.
module game_state_ctrl #(
  parameter int NUM_LEVELS = 4,
  parameter int NUM_LIVES = 3,
  parameter int RESPAWN_CYCLES = 16,
  parameter int CLEAR_CYCLES = 16,
  localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int VW = $clog2(NUM_LIVES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          restart,
  input  logic          over,
  input  logic          success,
  input  logic          pause,
  output logic [2:0]    state,
  output logic [LW-1:0] level,
  output logic [VW-1:0] lives,
  output logic          life_lost,
  output logic          level_up
);
  localparam int TMAX = (RESPAWN_CYCLES > CLEAR_CYCLES) ? RESPAWN_CYCLES : CLEAR_CYCLES;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [VW-1:0] LIVES0 = VW'(NUM_LIVES);
  localparam logic [LW-1:0] LAST = LW'(NUM_LEVELS - 1);
  typedef enum logic [2:0] {
    IDLE = 3'd0, PLAY = 3'd1, PAUSE = 3'd2, DYING = 3'd3,
    CLEAR = 3'd4, OVER = 3'd5, WIN = 3'd6
  } state_t;
  state_t st;
  logic [TW-1:0] timer;
  logic start_q, pause_q;
  logic start_rise, pause_rise;
  assign start_rise = start & ~start_q;
  assign pause_rise = pause & ~pause_q;
  assign state = st;
`ifndef GAME_PAUSE_EN
  logic unused;
  assign unused = pause_rise;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      level <= '0;
      lives <= LIVES0;
      timer <= '0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      life_lost <= 1'b0;
      level_up <= 1'b0;
    end else begin
      start_q <= start;
      pause_q <= pause;
      life_lost <= 1'b0;
      level_up <= 1'b0;
      if (restart) begin
        st <= IDLE;
        level <= '0;
        lives <= LIVES0;
        timer <= '0;
      end else
        case (st)
          IDLE, OVER, WIN:
            if (start_rise) begin
              st <= PLAY;
              level <= '0;
              lives <= LIVES0;
            end
          PLAY:
            if (over) begin
              life_lost <= 1'b1;
              if (lives > VW'(1)) begin
                st <= DYING;
                lives <= lives - VW'(1);
                timer <= TW'(RESPAWN_CYCLES - 1);
              end else begin
                st <= OVER;
                lives <= '0;
              end
            end else if (success) begin
              if (level == LAST) st <= WIN;
              else begin
                st <= CLEAR;
                timer <= TW'(CLEAR_CYCLES - 1);
              end
            end
`ifdef GAME_PAUSE_EN
            else if (pause_rise) st <= PAUSE;
          PAUSE:
            if (pause_rise) st <= PLAY;
`endif
          DYING:
            if (timer == '0) st <= PLAY;
            else timer <= timer - TW'(1);
          CLEAR:
            if (timer == '0) begin
              st <= PLAY;
              level <= level + LW'(1);
              level_up <= 1'b1;
            end else timer <= timer - TW'(1);
          default: begin
            st <= IDLE;
            level <= '0;
            lives <= LIVES0;
            timer <= '0;
          end
        endcase
    end
endmodule
